bp_bpred_event_queue: RTL and testbench
=======================================

BP_BPRED_EVENT_QUEUE -- requirements
Module: bp_bpred_event_queue

Interface
REQ-001 Parameter vaddr_width_p, default 39: width of the branch target virtual address.
REQ-002 Parameter els_p, default 4: queue depth; SHALL be a power of two, at least 2.
REQ-003 Parameter drop_width_p, default 16: width of the drop counter.
REQ-004 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset_i  input  1  asynchronous, active-low reset; the block is in reset while reset_i=0.
REQ-006 ev_v_i  input  1  branch event from the fetch predictor this cycle; cannot be stalled.
REQ-007 ev_br_target_i  input  vaddr_width_p  predicted or override branch target.
REQ-008 ev_ovr_taken_i  input  1  the second-stage predictor overrode to taken.
REQ-009 ev_ovr_ntaken_i  input  1  the second-stage predictor overrode to not-taken.
REQ-010 flush_i  input  1  discards all queued events.
REQ-011 ready_i  input  1  the downstream branch-predict trace consumer accepts the head event.
REQ-012 is_br_o  output  1  head event valid.
REQ-013 br_target_o  output  vaddr_width_p  head event target.
REQ-014 ovr_taken_o  output  1  head event taken override.
REQ-015 ovr_ntaken_o  output  1  head event not-taken override.
REQ-016 full_o  output  1  occupancy equals els_p.
REQ-017 drop_cnt_o  output  drop_width_p  number of events lost to overflow, saturating.

Function
REQ-018 Storage SHALL be a circular buffer of els_p entries, each holding {target, ovr_taken, ovr_ntaken}, with log2(els_p)-bit read and write pointers and a (log2(els_p)+1)-bit occupancy count.
REQ-019 Enqueue SHALL happen on an edge where ev_v_i=1, flush_i=0, and either the count is below els_p or a dequeue occurs on the same edge.
REQ-020 Dequeue SHALL happen on an edge where is_br_o=1, ready_i=1 and flush_i=0.
REQ-021 Outputs SHALL be first-word fall-through: is_br_o = (count != 0), and the head fields are driven combinationally from the read pointer entry.
REQ-022 When the queue is empty, br_target_o, ovr_taken_o and ovr_ntaken_o SHALL be 0.
REQ-023 When an enqueue and a dequeue occur on the same edge, the count SHALL be unchanged and both pointers SHALL advance; this also applies when the queue is full.
REQ-024 Pointers SHALL wrap from els_p-1 to 0.
REQ-025 When ev_v_i=1 and the event is not enqueued and flush_i=0, the event SHALL be discarded and drop_cnt_o SHALL increment by 1; it holds at all-ones once saturated.
REQ-026 When ev_ovr_taken_i=ev_ovr_ntaken_i=1, the stored ovr_ntaken SHALL be 0 (taken has priority).
REQ-027 flush_i=1 SHALL zero the pointers and count on that edge and SHALL override any enqueue or dequeue on the same edge.
REQ-028 flush_i=1 SHALL NOT change drop_cnt_o, and an event presented in a flush cycle SHALL NOT count as dropped.
REQ-029 Enqueue-to-visible latency SHALL be one cycle: is_br_o rises the cycle after the edge that enqueued into an empty queue.
REQ-030 full_o SHALL be a registered-state decode (count == els_p), with no combinational path from the inputs.

Reset
REQ-031 While reset_i=0, the pointers, count and drop_cnt_o SHALL be 0 asynchronously, giving is_br_o=0, full_o=0 and head fields 0.
REQ-032 Entry storage need not be reset.
REQ-033 Reset asserted mid-operation SHALL discard all queued events within the same cycle.
REQ-034 The first enqueue SHALL be possible on the first rising edge after reset_i deasserts.

Verification
REQ-035 Basic ordering: enqueue targets 0x100, 0x200, 0x300 with ready_i=0, then set ready_i=1 -> the three events emerge in order on consecutive cycles, then is_br_o=0.
REQ-036 Overflow: els_p=4, ready_i=0, six events presented -> full_o=1 after the 4th, drop_cnt_o=2, and the four oldest events are retained.
REQ-037 Full with simultaneous push/pop: queue full, ev_v_i=1, ready_i=1 for 3 cycles -> drop_cnt_o unchanged, full_o stays 1, and output order is FIFO across the pointer wrap.
REQ-038 Flush: 3 events queued, flush_i=1 with ev_v_i=1 and ready_i=1 -> next cycle is_br_o=0, count 0, drop_cnt_o unchanged.
REQ-039 Override conflict: event with ovr_taken=1, ovr_ntaken=1, target 0x7F0 -> output ovr_taken_o=1, ovr_ntaken_o=0, target 0x7F0.
REQ-040 Async reset: reset_i driven to 0 between edges with 2 events queued and drop_cnt_o=5 -> is_br_o=0 and drop_cnt_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bp_bpred_event_queue.sv
// Branch-predict event queue: first-word fall-through circular buffer
// between the fetch predictor and the trace consumer, with a drop counter.
module bp_bpred_event_queue #(
    parameter int vaddr_width_p = 39,
    parameter int els_p         = 4,
    parameter int drop_width_p  = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     ev_v_i,
    input  logic [vaddr_width_p-1:0] ev_br_target_i,
    input  logic                     ev_ovr_taken_i,
    input  logic                     ev_ovr_ntaken_i,
    input  logic                     flush_i,
    input  logic                     ready_i,
    output logic                     is_br_o,
    output logic [vaddr_width_p-1:0] br_target_o,
    output logic                     ovr_taken_o,
    output logic                     ovr_ntaken_o,
    output logic                     full_o,
    output logic [drop_width_p-1:0]  drop_cnt_o
);

    localparam int ptr_w = $clog2(els_p);

    typedef struct packed {
        logic [vaddr_width_p-1:0] target;
        logic                     ovr_taken;
        logic                     ovr_ntaken;
    } entry_t;

    entry_t            mem [els_p];
    logic [ptr_w-1:0]  rptr;
    logic [ptr_w-1:0]  wptr;
    logic [ptr_w:0]    cnt;
    logic              deq;
    logic              enq;
    logic              drop;
    entry_t            head;

    assign is_br_o = (cnt != '0);
    assign full_o  = (cnt == (ptr_w+1)'(els_p));

    assign deq  = is_br_o & ready_i & ~flush_i;
    assign enq  = ev_v_i & ~flush_i & (~full_o | deq);
    assign drop = ev_v_i & ~flush_i & ~enq;

    assign head         = is_br_o ? mem[rptr] : '0;
    assign br_target_o  = head.target;
    assign ovr_taken_o  = head.ovr_taken;
    assign ovr_ntaken_o = head.ovr_ntaken;

    // Storage carries no reset; validity comes solely from cnt.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem[wptr].target     <= ev_br_target_i;
            mem[wptr].ovr_taken  <= ev_ovr_taken_i;
            mem[wptr].ovr_ntaken <= ev_ovr_ntaken_i & ~ev_ovr_taken_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rptr <= '0;
            wptr <= '0;
            cnt  <= '0;
        end else if (flush_i) begin
            rptr <= '0;
            wptr <= '0;
            cnt  <= '0;
        end else begin
            if (enq) wptr <= wptr + ptr_w'(1);
            if (deq) rptr <= rptr + ptr_w'(1);
            if (enq && !deq) cnt <= cnt + 1'b1;
            else if (deq && !enq) cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            drop_cnt_o <= '0;
        end else if (drop && drop_cnt_o != '1) begin
            drop_cnt_o <= drop_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_bp_bpred_event_queue.sv
// Randomized bench for bp_bpred_event_queue against a queue-based
// reference model, plus directed ordering/overflow/flush/reset cases.
module tb_bp_bpred_event_queue;

    localparam int VW  = 39;
    localparam int ELS = 4;
    localparam int DW  = 16;

    logic          clk;
    logic          reset_n;
    logic          ev_v;
    logic [VW-1:0] ev_tgt;
    logic          ev_t;
    logic          ev_nt;
    logic          flush;
    logic          ready;
    logic          is_br;
    logic [VW-1:0] br_tgt;
    logic          o_t;
    logic          o_nt;
    logic          full;
    logic [DW-1:0] drop_cnt;

    bp_bpred_event_queue #(
        .vaddr_width_p(VW),
        .els_p(ELS),
        .drop_width_p(DW)
    ) dut (
        .clk_i(clk),
        .reset_i(reset_n),
        .ev_v_i(ev_v),
        .ev_br_target_i(ev_tgt),
        .ev_ovr_taken_i(ev_t),
        .ev_ovr_ntaken_i(ev_nt),
        .flush_i(flush),
        .ready_i(ready),
        .is_br_o(is_br),
        .br_target_o(br_tgt),
        .ovr_taken_o(o_t),
        .ovr_ntaken_o(o_nt),
        .full_o(full),
        .drop_cnt_o(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [VW-1:0] tgt;
        logic          t;
        logic          nt;
    } ev_t_s;

    ev_t_s q[$];
    int    m_drop;
    int    n_checks;
    int    n_errors;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".is_br"}, 64'(is_br), 64'(q.size() != 0));
        chk({tag, ".full"}, 64'(full), 64'(q.size() == ELS));
        chk({tag, ".drop"}, 64'(drop_cnt), 64'(m_drop));
        if (q.size() != 0) begin
            chk({tag, ".tgt"}, 64'(br_tgt), 64'(q[0].tgt));
            chk({tag, ".t"}, 64'(o_t), 64'(q[0].t));
            chk({tag, ".nt"}, 64'(o_nt), 64'(q[0].nt));
        end else begin
            chk({tag, ".tgt0"}, 64'(br_tgt), 64'd0);
            chk({tag, ".t0"}, 64'(o_t), 64'd0);
            chk({tag, ".nt0"}, 64'(o_nt), 64'd0);
        end
    endtask

    // Called at a negedge: drive inputs, advance model, check next negedge.
    task automatic cycle(input logic v, input logic [VW-1:0] tgt,
                         input logic t, input logic nt,
                         input logic fl, input logic rd,
                         input string tag);
        bit    do_deq;
        bit    do_enq;
        ev_t_s e;
        ev_v   = v;
        ev_tgt = tgt;
        ev_t   = t;
        ev_nt  = nt;
        flush  = fl;
        ready  = rd;
        if (fl) begin
            q.delete();
        end else begin
            do_deq = (q.size() != 0) && rd;
            do_enq = v && ((q.size() < ELS) || do_deq);
            if (do_deq) void'(q.pop_front());
            if (do_enq) begin
                e.tgt = tgt;
                e.t   = t;
                e.nt  = nt && !t;
                q.push_back(e);
            end else if (v && m_drop < (1 << DW) - 1) begin
                m_drop++;
            end
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic idle(input logic rd, input string tag);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, rd, tag);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        q.delete();
        m_drop = 0;
        repeat (2) @(negedge clk);
        check_outputs("reset");
        reset_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_drop   = 0;
        reset_n  = 1'b0;
        ev_v     = 1'b0;
        ev_tgt   = '0;
        ev_t     = 1'b0;
        ev_nt    = 1'b0;
        flush    = 1'b0;
        ready    = 1'b0;
        @(negedge clk);
        do_reset();

        // Ordering
        cycle(1, 39'h100, 0, 0, 0, 0, "ord_in0");
        cycle(1, 39'h200, 0, 1, 0, 0, "ord_in1");
        cycle(1, 39'h300, 1, 0, 0, 0, "ord_in2");
        repeat (4) idle(1, "ord_out");

        // Overflow: six events into depth four
        for (int i = 0; i < 6; i++)
            cycle(1, 39'(16'h1000 + i), 0, 0, 0, 0, "ovf");
        chk("ovf.drop2", 64'(drop_cnt), 64'd2);
        chk("ovf.head", 64'(br_tgt), 64'h1000);

        // Full with simultaneous push/pop across the wrap
        for (int i = 0; i < 3; i++)
            cycle(1, 39'(16'h2000 + i), 0, 0, 0, 1, "fullpp");
        chk("fullpp.full", 64'(full), 64'd1);
        repeat (5) idle(1, "fullpp_drain");

        // Override conflict
        cycle(1, 39'h7F0, 1, 1, 0, 0, "ovr");
        chk("ovr.nt", 64'(o_nt), 64'd0);
        idle(1, "ovr_drain");

        // Flush with concurrent event and ready
        for (int i = 0; i < 3; i++)
            cycle(1, 39'(16'h3000 + i), 0, 0, 0, 0, "fl_in");
        cycle(1, 39'h3FFF, 0, 0, 1, 1, "flush");
        chk("flush.empty", 64'(is_br), 64'd0);

        // Async reset with two queued and drop_cnt five
        do_reset();
        for (int i = 0; i < 9; i++)
            cycle(1, 39'(16'h4000 + i), 0, 0, 0, 0, "ar_fill");
        idle(1, "ar_pop");
        idle(1, "ar_pop");
        chk("ar.drop5", 64'(drop_cnt), 64'd5);
        chk("ar.is_br_pre", 64'(is_br), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar.is_br", 64'(is_br), 64'd0);
        chk("ar.drop", 64'(drop_cnt), 64'd0);
        chk("ar.full", 64'(full), 64'd0);
        q.delete();
        m_drop = 0;
        @(negedge clk);
        reset_n = 1'b1;
        cycle(1, 39'h5555, 0, 1, 0, 0, "first_after_reset");

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 3) != 0),
                  {$urandom, $urandom} % (64'd1 << VW),
                  1'($urandom), 1'($urandom),
                  1'($urandom_range(0, 39) == 0),
                  1'($urandom_range(0, 9) < 4),
                  "rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
